// File: rtl/proc_dispatch.sv
// proc_dispatch: holds one upstream command, offers it round-robin to a free
// processor until acked, tracks in-flight work and returns completions.

`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

package proc_dispatch_pkg;
  typedef logic [31:0] instr_t;
  typedef logic [7:0]  cmd_id_t;
endpackage

// One processor slot: in flight from ack to finish, then pending until popped.
module proc_dispatch_lane
  import proc_dispatch_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_issue,
  input  logic    i_finish,
  input  cmd_id_t i_id,
  input  logic    i_pop,
  output logic    o_inflight,
  output logic    o_done_pend,
  output cmd_id_t o_done_id,
  output logic    o_fin_take
);
  // Finishes from a slot with nothing in flight are dropped here.
  assign o_fin_take = i_finish & o_inflight;

  // Issue and finish never coincide (issue needs the slot idle); finish and pop
  // never coincide either (pending and in-flight are exclusive).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_inflight  <= 1'b0;
      o_done_pend <= 1'b0;
      o_done_id   <= '0;
    end else begin
      if (i_issue)         o_inflight <= 1'b1;
      else if (o_fin_take) o_inflight <= 1'b0;
      if (o_fin_take) begin
        o_done_pend <= 1'b1;
        o_done_id   <= i_id;
      end else if (i_pop) begin
        o_done_pend <= 1'b0;
      end
    end
  end
endmodule

module proc_dispatch
  import proc_dispatch_pkg::*;
#(
  parameter  int NPROC       = `PROC_COUNT,
  parameter  int ACK_TIMEOUT = 64,
  localparam int PW          = $clog2(NPROC)
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  input  instr_t               i_cmd,
  output logic                 o_cmd_ready,
  output instr_t  [NPROC-1:0]  o_instr,
  output logic    [NPROC-1:0]  o_en,
  output logic    [NPROC-1:0]  o_valid,
  input  logic    [NPROC-1:0]  i_busy,
  input  logic    [NPROC-1:0]  i_ack,
  input  logic    [NPROC-1:0]  i_finish,
  input  cmd_id_t [NPROC-1:0]  i_id,
  output logic                 o_done_valid,
  output cmd_id_t              o_done_id,
  output logic    [PW-1:0]     o_done_proc,
  input  logic                 i_done_ready,
  output logic    [NPROC-1:0]  o_fault,
  output logic                 o_idle
);
  localparam int TW = $clog2(ACK_TIMEOUT);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t              state;
  logic                cmd_full;
  instr_t              cmd_q;
  logic    [PW-1:0]    sel;
  logic    [PW-1:0]    rr_ptr;
  logic    [TW-1:0]    tmr;
  logic    [NPROC-1:0] inflight, done_pend, fin_take, issue, pop, elig;
  cmd_id_t [NPROC-1:0] done_id;
  logic                pick_found, done_found, ack_sel;
  logic    [PW-1:0]    pick, done_sel;

  assign o_cmd_ready  = ~cmd_full;
  assign elig         = ~i_busy & ~inflight & ~done_pend & ~o_fault;
  assign ack_sel      = (state == OFFER) & i_ack[sel];
  assign o_done_valid = done_found;
  assign o_done_id    = done_id[done_sel];
  assign o_done_proc  = done_sel;
  assign o_idle       = ~cmd_full & ~|inflight & ~|done_pend & (state == IDLE);

  // Round-robin search: first eligible processor at or after rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    for (int k = 0; k < NPROC; k++) begin
      if (!pick_found && elig[(int'(rr_ptr) + k) % NPROC]) begin
        pick_found = 1'b1;
        pick       = PW'((int'(rr_ptr) + k) % NPROC);
      end
    end
  end

  // Completions are returned lowest processor index first.
  always_comb begin
    done_found = 1'b0;
    done_sel   = '0;
    for (int p = 0; p < NPROC; p++) begin
      if (!done_found && done_pend[p]) begin
        done_found = 1'b1;
        done_sel   = PW'(p);
      end
    end
  end

  for (genvar p = 0; p < NPROC; p++) begin : g_lane
    assign o_instr[p] = cmd_q;
    assign issue[p]   = ack_sel & (sel == PW'(p));
    assign pop[p]     = o_done_valid & i_done_ready & (done_sel == PW'(p));

    proc_dispatch_lane u_lane (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_issue     (issue[p]),
      .i_finish    (i_finish[p]),
      .i_id        (i_id[p]),
      .i_pop       (pop[p]),
      .o_inflight  (inflight[p]),
      .o_done_pend (done_pend[p]),
      .o_done_id   (done_id[p]),
      .o_fin_take  (fin_take[p])
    );
  end

  // Intake register plus the offer FSM; an ack in the expiry cycle beats the timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cmd_full <= 1'b0;
      cmd_q    <= '0;
      sel      <= '0;
      rr_ptr   <= '0;
      tmr      <= '0;
      o_valid  <= '0;
      o_en     <= '0;
      o_fault  <= '0;
    end else begin
      if (i_cmd_valid && !cmd_full) begin
        cmd_full <= 1'b1;
        cmd_q    <= i_cmd;
      end
      o_en <= o_en & ~fin_take;
      case (state)
        IDLE: begin
          if (cmd_full && pick_found) begin
            sel           <= pick;
            o_valid[pick] <= 1'b1;
            o_en[pick]    <= 1'b1;
            tmr           <= '0;
            state         <= OFFER;
          end
        end
        OFFER: begin
          if (i_ack[sel]) begin
            o_valid  <= '0;
            cmd_full <= 1'b0;
            rr_ptr   <= (sel == PW'(NPROC - 1)) ? '0 : sel + 1'b1;
            state    <= IDLE;
          end else if (tmr == TW'(ACK_TIMEOUT - 1)) begin
            // Dead processor: retire it and leave the command held for reissue.
            o_valid      <= '0;
            o_en[sel]    <= 1'b0;
            o_fault[sel] <= 1'b1;
            state        <= IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_proc_dispatch.sv
// Directed scenarios followed by randomized traffic checked against a
// transaction-level model of the dispatcher.
module tb_proc_dispatch;
  localparam int NP = 4;
  localparam int TO = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cmd_valid;
  logic [31:0]           cmd;
  logic                  cmd_ready;
  logic [NP-1:0][31:0]   instr;
  logic [NP-1:0]         en, vld, busy, ack, fin, fault;
  logic [NP-1:0][7:0]    id;
  logic                  done_valid;
  logic [7:0]            done_id;
  logic [1:0]            done_proc;
  logic                  done_ready;
  logic                  idle;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_full;
  logic [31:0] m_cmd;
  int          m_off, m_wait, m_rr, dead;
  bit [NP-1:0] m_infl, m_pend, m_fault;
  logic [7:0]  m_id [NP];

  always #5 clk = ~clk;

  proc_dispatch #(.NPROC(NP), .ACK_TIMEOUT(TO)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .i_cmd        (cmd),
    .o_cmd_ready  (cmd_ready),
    .o_instr      (instr),
    .o_en         (en),
    .o_valid      (vld),
    .i_busy       (busy),
    .i_ack        (ack),
    .i_finish     (fin),
    .i_id         (id),
    .o_done_valid (done_valid),
    .o_done_id    (done_id),
    .o_done_proc  (done_proc),
    .i_done_ready (done_ready),
    .o_fault      (fault),
    .o_idle       (idle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; ack = '0; fin = '0; busy = '0;
    id = '0; done_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_vld"},   64'(vld),        64'h0);
    chk({t, "_en"},    64'(en),         64'h0);
    chk({t, "_fault"}, 64'(fault),      64'h0);
    chk({t, "_rdy"},   64'(cmd_ready),  64'h1);
    chk({t, "_dv"},    64'(done_valid), 64'h0);
    chk({t, "_idle"},  64'(idle),       64'h1);
  endtask

  // Send a command, expect it offered on exp_v, ack it immediately.
  task automatic issue_ack(input logic [31:0] c, input logic [NP-1:0] exp_v, input string t);
    int idx;
    idx = 0;
    for (int p = 0; p < NP; p++) if (exp_v[p]) idx = p;
    cmd_valid = 1'b1; cmd = c;
    step();
    cmd_valid = 1'b0;
    step();
    chk({t, "_vld"},   64'(vld),        64'(exp_v));
    chk({t, "_instr"}, 64'(instr[idx]), 64'(c));
    ack = exp_v;
    step();
    ack = '0;
    chk({t, "_off"}, 64'(vld),       64'h0);
    chk({t, "_rdy"}, 64'(cmd_ready), 64'h1);
  endtask

  function automatic int lowest(input bit [NP-1:0] v);
    for (int p = 0; p < NP; p++) if (v[p]) return p;
    return -1;
  endfunction

  task automatic m_reset();
    m_full = 0; m_cmd = '0; m_off = -1; m_wait = 0; m_rr = 0;
    m_infl = '0; m_pend = '0; m_fault = '0;
    for (int p = 0; p < NP; p++) m_id[p] = '0;
  endtask

  // Compare DUT outputs against the model's view of the world.
  task automatic m_check();
    logic [NP-1:0] exp_v;
    int lo;
    exp_v = '0;
    if (m_off >= 0) exp_v[m_off] = 1'b1;
    lo = lowest(m_pend);
    chk("r_vld",   64'(vld),        64'(exp_v));
    chk("r_en",    64'(en),         64'(exp_v | m_infl));
    chk("r_rdy",   64'(cmd_ready),  64'(!m_full));
    chk("r_fault", 64'(fault),      64'(m_fault));
    chk("r_dv",    64'(done_valid), 64'(m_pend != 0));
    chk("r_idle",  64'(idle),       64'(!m_full && m_infl == 0 && m_pend == 0 && m_off < 0));
    if (lo >= 0) chk("r_done", 64'({done_proc, done_id}), 64'({2'(lo), m_id[lo]}));
    if (m_off >= 0) chk("r_instr", 64'(instr[m_off]), 64'(m_cmd));
  endtask

  // Advance the model by one clock given the inputs currently driven.
  task automatic m_step();
    bit          was_full;
    bit [NP-1:0] n_infl, n_pend;
    int          lo, pick, q;
    was_full = m_full;
    n_infl   = m_infl;
    n_pend   = m_pend;
    lo       = lowest(m_pend);
    for (int p = 0; p < NP; p++)
      if (fin[p] && m_infl[p]) begin
        n_infl[p] = 0; n_pend[p] = 1; m_id[p] = id[p];
      end
    if (lo >= 0 && done_ready) n_pend[lo] = 0;
    if (m_off < 0) begin
      if (m_full) begin
        pick = -1;
        for (int k = 0; k < NP; k++) begin
          q = (m_rr + k) % NP;
          if (pick < 0 && !busy[q] && !m_infl[q] && !m_pend[q] && !m_fault[q]) pick = q;
        end
        if (pick >= 0) begin m_off = pick; m_wait = 0; end
      end
    end else if (ack[m_off]) begin
      n_infl[m_off] = 1; m_rr = (m_off + 1) % NP; m_full = 0; m_off = -1;
    end else if (m_wait == TO - 1) begin
      m_fault[m_off] = 1; m_off = -1;
    end else begin
      m_wait++;
    end
    if (cmd_valid && !was_full) begin m_full = 1; m_cmd = cmd; end
    m_infl = n_infl;
    m_pend = n_pend;
  endtask

  initial begin
    // 1: single command, ack two cycles after the offer appears
    do_reset();
    chk_reset("t1_rst");
    cmd_valid = 1'b1; cmd = 32'hA0A0_0001;
    step();
    cmd_valid = 1'b0;
    chk("t1_rdy_lo", 64'(cmd_ready), 64'h0);
    chk("t1_vld_n",  64'(vld),       64'h0);
    step();
    chk("t1_vld",   64'(vld),      64'h1);
    chk("t1_en",    64'(en),       64'h1);
    chk("t1_instr", 64'(instr[0]), 64'hA0A0_0001);
    step();
    chk("t1_hold", 64'(vld), 64'h1);
    ack = 4'b0001;
    step();
    ack = '0;
    chk("t1_off",  64'(vld),       64'h0);
    chk("t1_rdy",  64'(cmd_ready), 64'h1);
    chk("t1_infl", 64'(en),        64'h1);
    chk("t1_idle", 64'(idle),      64'h0);

    // 2: round-robin over all four, fifth command stays held
    do_reset();
    issue_ack(32'hB000_0000, 4'b0001, "t2_c0");
    issue_ack(32'hB000_0001, 4'b0010, "t2_c1");
    issue_ack(32'hB000_0002, 4'b0100, "t2_c2");
    issue_ack(32'hB000_0003, 4'b1000, "t2_c3");
    cmd_valid = 1'b1; cmd = 32'hB000_0004;
    step();
    cmd_valid = 1'b0;
    step(); step();
    chk("t2_held_vld", 64'(vld),       64'h0);
    chk("t2_held_rdy", 64'(cmd_ready), 64'h0);
    chk("t2_held_en",  64'(en),        64'hF);

    // 3: two finishes in one cycle, drained lowest index first
    fin = 4'b1010; id[1] = 8'h11; id[3] = 8'h33; done_ready = 1'b1;
    step();
    fin = '0;
    chk("t3_dv",   64'(done_valid),           64'h1);
    chk("t3_d1",   64'({done_proc, done_id}), 64'({2'd1, 8'h11}));
    chk("t3_en",   64'(en),                   64'h5);
    step();
    chk("t3_d3",   64'({done_proc, done_id}), 64'({2'd3, 8'h33}));
    chk("t3_wait", 64'(vld),                  64'h0);
    step();
    chk("t3_dv0",  64'(done_valid), 64'h0);
    chk("t3_re",   64'(vld),        64'h2);
    chk("t3_instr",64'(instr[1]),   64'hB000_0004);
    ack = 4'b0010;
    step();
    ack = '0; done_ready = 1'b0;
    chk("t3_rdy", 64'(cmd_ready), 64'h1);

    // 4: pending completion on proc 0 blocks it from issue
    do_reset();
    issue_ack(32'hC000_0000, 4'b0001, "t4_c0");
    fin = 4'b0001; id[0] = 8'h5A;
    step();
    fin = '0;
    chk("t4_dv", 64'(done_valid), 64'h1);
    busy = 4'b0110;
    issue_ack(32'hC000_0001, 4'b1000, "t4_c1");
    busy = '0;
    issue_ack(32'hC000_0002, 4'b0010, "t4_skip");
    chk("t4_dv_hold", 64'(done_valid),           64'h1);
    chk("t4_id_hold", 64'({done_proc, done_id}), 64'({2'd0, 8'h5A}));
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk("t4_pop", 64'(done_valid), 64'h0);

    // 5: ack timeout faults proc 0; proc 1 acks in its expiry cycle
    do_reset();
    cmd_valid = 1'b1; cmd = 32'hD00D_0005;
    step();
    cmd_valid = 1'b0;
    step();
    chk("t5_vld0", 64'(vld), 64'h1);
    repeat (TO - 1) step();
    chk("t5_pre_vld",   64'(vld),   64'h1);
    chk("t5_pre_fault", 64'(fault), 64'h0);
    step();
    chk("t5_fault", 64'(fault),     64'h1);
    chk("t5_drop",  64'(vld),       64'h0);
    chk("t5_en",    64'(en),        64'h0);
    chk("t5_rdy",   64'(cmd_ready), 64'h0);
    step();
    chk("t5_re",    64'(vld),      64'h2);
    chk("t5_instr", 64'(instr[1]), 64'hD00D_0005);
    repeat (TO - 1) step();
    chk("t5_late_vld", 64'(vld), 64'h2);
    ack = 4'b0010;
    step();
    ack = '0;
    chk("t5_win_vld",   64'(vld),       64'h0);
    chk("t5_win_rdy",   64'(cmd_ready), 64'h1);
    chk("t5_win_fault", 64'(fault),     64'h1);
    chk("t5_win_en",    64'(en),        64'h2);

    // 6: reset while offering and with a completion pending
    fin = 4'b0010; id[1] = 8'h77;
    step();
    fin = '0;
    chk("t6_dv", 64'(done_valid), 64'h1);
    cmd_valid = 1'b1; cmd = 32'hE000_0006;
    step();
    cmd_valid = 1'b0;
    step();
    chk("t6_offer", 64'(vld), 64'h4);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("t6_rst");

    // randomized traffic; one proc may be dead per epoch
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 0) begin
        do_reset();
        m_reset();
        dead = (c == 0) ? -1 : int'($urandom_range(0, NP - 1));
      end
      m_check();
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd        = $urandom();
      done_ready = 1'($urandom_range(0, 1));
      ack        = 4'($urandom()) & 4'($urandom());
      if (m_off >= 0 && m_off == dead) ack[m_off] = 1'b0;
      for (int p = 0; p < NP; p++) begin
        busy[p] = ($urandom_range(0, 3) == 0);
        fin[p]  = ($urandom_range(0, 5) == 0);
        id[p]   = 8'($urandom());
      end
      m_step();
      step();
    end
    m_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
